// File: rtl/intrusion_detector_pkg.sv
// Shared types and constants for the intrusion detector. The sound generator's
// distance-based pitch logic uses the same thresholds.
package intrusion_detector_pkg;

   typedef enum logic [1:0] {
      ST_DISARMED = 2'd0,
      ST_ARMING   = 2'd1,
      ST_ARMED    = 2'd2,
      ST_ALARM    = 2'd3
   } state_t;

   localparam int unsigned THRESH_NEAR_DFLT  = 32'd100;
   localparam int unsigned THRESH_CLEAR_DFLT = 32'd110;

   // Near below near_lim, clear at or above clear_lim, hold in between.
   function automatic logic hyst_near(input int unsigned avg, input logic held,
                                      input int unsigned near_lim, input int unsigned clear_lim);
      logic res;
      if (avg < near_lim) begin
         res = 1'b1;
      end else if (avg >= clear_lim) begin
         res = 1'b0;
      end else begin
         res = held;
      end
      return res;
   endfunction

endpackage

// File: rtl/intrusion_detector_if.sv
// Sample/control inputs and status outputs of the intrusion detector.
interface intrusion_detector_if #(parameter int DIST_W = 8);
   logic              Sample_Valid;
   logic [DIST_W-1:0] Sample;
   logic              Arm;
   logic              Clear;
   logic [DIST_W-1:0] Avg_Distance;
   logic              Avg_Valid;
   logic              Near;
   logic              Alarm;
   logic [1:0]        State;
   logic              Fault;

   modport master (
      output Sample_Valid, Sample, Arm, Clear,
      input  Avg_Distance, Avg_Valid, Near, Alarm, State, Fault
   );

   modport slave (
      input  Sample_Valid, Sample, Arm, Clear,
      output Avg_Distance, Avg_Valid, Near, Alarm, State, Fault
   );
endinterface

// File: rtl/intrusion_detector_moving_average.sv
// Power-of-two moving average over accepted (non-zero) samples; the strobe
// fires only once the window has been filled.
module moving_average #(
   parameter int DIST_W   = 8,
   parameter int AVG_LOG2 = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              sample_valid,
   input  logic [DIST_W-1:0] sample,
   output logic [DIST_W-1:0] avg,
   output logic              avg_valid
);
   localparam int WIN    = 1 << AVG_LOG2;
   localparam int SUM_W  = DIST_W + AVG_LOG2;
   localparam int FILL_W = AVG_LOG2 + 1;

   logic [DIST_W-1:0] samp_r [WIN];
   logic [SUM_W-1:0]  sum_r;
   logic [FILL_W-1:0] fill_r;
   logic [DIST_W-1:0] avg_r;
   logic              avg_valid_r;
   logic              accept_s;
   logic [SUM_W-1:0]  sum_nxt_s;
   logic [FILL_W-1:0] fill_nxt_s;

   // Zero is the sensor's out-of-range code; empty slots hold 0 so the running sum stays exact.
   assign accept_s   = sample_valid && (sample != {DIST_W{1'b0}});
   assign sum_nxt_s  = sum_r + SUM_W'(sample) - SUM_W'(samp_r[WIN-1]);
   assign fill_nxt_s = (fill_r == FILL_W'(WIN)) ? fill_r : fill_r + FILL_W'(1);

   // Shift buffer, running sum, fill count and registered average.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < WIN; i++) samp_r[i] <= {DIST_W{1'b0}};
         sum_r       <= {SUM_W{1'b0}};
         fill_r      <= {FILL_W{1'b0}};
         avg_r       <= {DIST_W{1'b0}};
         avg_valid_r <= 1'b0;
      end else begin
         avg_valid_r <= 1'b0;
         if (accept_s) begin
            samp_r[0] <= sample;
            for (int i = 1; i < WIN; i++) samp_r[i] <= samp_r[i-1];
            sum_r       <= sum_nxt_s;
            fill_r      <= fill_nxt_s;
            avg_r       <= DIST_W'(sum_nxt_s >> AVG_LOG2);
            avg_valid_r <= (fill_nxt_s == FILL_W'(WIN));
         end
      end
   end

   assign avg       = avg_r;
   assign avg_valid = avg_valid_r;
endmodule

// File: rtl/intrusion_detector.sv
// Intrusion detector: averaged distance, near hysteresis, arm/alarm FSM and
// sensor-silence tamper detection.
module intrusion_detector
   import intrusion_detector_pkg::*;
#(
   parameter int          DIST_W       = 8,
   parameter int          AVG_LOG2     = 2,
   parameter int unsigned THRESH_NEAR  = THRESH_NEAR_DFLT,
   parameter int unsigned THRESH_CLEAR = THRESH_CLEAR_DFLT,
   parameter int          CONFIRM_CNT  = 3,
   parameter int          ARM_DELAY    = 8,
   parameter int          TIMEOUT_CYC  = 2_000_000
) (
   input  logic CLK,
   input  logic RST,
   intrusion_detector_if.slave bus
);
   localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int ARM_W  = $clog2(ARM_DELAY + 1);
   localparam int CONF_W = $clog2(CONFIRM_CNT + 1);

   logic [DIST_W-1:0] avg_s;
   logic              avg_valid_s;
   logic              near_now_s;
   logic              fault_set_s;
   logic              near_r;
   logic              alarm_r;
   logic              fault_r;
   state_t            state_r;
   logic [TMO_W-1:0]  tmo_cnt_r;
   logic [ARM_W-1:0]  arm_cnt_r;
   logic [CONF_W-1:0] confirm_r;

   moving_average #(.DIST_W(DIST_W), .AVG_LOG2(AVG_LOG2)) u_avg (
      .CLK          (CLK),
      .RST          (RST),
      .sample_valid (bus.Sample_Valid),
      .sample       (bus.Sample),
      .avg          (avg_s),
      .avg_valid    (avg_valid_s)
   );

   assign near_now_s  = (32'(avg_s) < THRESH_NEAR);
   // Fault rises on exactly the cycle the counter reaches the limit.
   assign fault_set_s = !bus.Sample_Valid && (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));

   // Sensor-silence counter; saturates at the limit with Fault held.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
         fault_r   <= 1'b0;
      end else if (bus.Sample_Valid) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
         fault_r   <= 1'b0;
      end else if (tmo_cnt_r != TMO_W'(TIMEOUT_CYC)) begin
         tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
         fault_r   <= fault_r | fault_set_s;
      end
   end

   // Near hysteresis, updated on every new average.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         near_r <= 1'b0;
      end else if (avg_valid_s) begin
         near_r <= hyst_near(32'(avg_s), near_r, THRESH_NEAR, THRESH_CLEAR);
      end
   end

   // Arm/alarm state machine; Arm low overrides everything else.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r   <= ST_DISARMED;
         alarm_r   <= 1'b0;
         arm_cnt_r <= {ARM_W{1'b0}};
         confirm_r <= {CONF_W{1'b0}};
      end else if (!bus.Arm) begin
         state_r   <= ST_DISARMED;
         alarm_r   <= 1'b0;
         arm_cnt_r <= {ARM_W{1'b0}};
         confirm_r <= {CONF_W{1'b0}};
      end else begin
         case (state_r)
            ST_DISARMED: begin
               state_r   <= ST_ARMING;
               arm_cnt_r <= {ARM_W{1'b0}};
            end
            ST_ARMING: begin
               if (avg_valid_s) begin
                  if (arm_cnt_r == ARM_W'(ARM_DELAY - 1)) begin
                     state_r   <= ST_ARMED;
                     confirm_r <= {CONF_W{1'b0}};
                  end
                  arm_cnt_r <= arm_cnt_r + ARM_W'(1);
               end
            end
            ST_ARMED: begin
               if (fault_set_s) begin
                  state_r <= ST_ALARM;
                  alarm_r <= 1'b1;
               end else if (avg_valid_s) begin
                  if (near_now_s) begin
                     confirm_r <= confirm_r + CONF_W'(1);
                     if (confirm_r == CONF_W'(CONFIRM_CNT - 1)) begin
                        state_r <= ST_ALARM;
                        alarm_r <= 1'b1;
                     end
                  end else begin
                     confirm_r <= {CONF_W{1'b0}};
                  end
               end
            end
            ST_ALARM: begin
               if (bus.Clear) begin
                  state_r   <= ST_ARMING;
                  alarm_r   <= 1'b0;
                  arm_cnt_r <= {ARM_W{1'b0}};
               end
            end
            default: begin
               state_r <= ST_DISARMED;
               alarm_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Avg_Distance = avg_s;
   assign bus.Avg_Valid    = avg_valid_s;
   assign bus.Near         = near_r;
   assign bus.Alarm        = alarm_r;
   assign bus.State        = state_r;
   assign bus.Fault        = fault_r;
endmodule

// File: tb/tb_intrusion_detector.sv
// Scoreboard bench for intrusion_detector: a window/threshold reference model
// queues expected averages; a monitor checks them as Avg_Valid appears.
module tb_intrusion_detector;
   import intrusion_detector_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   intrusion_detector_if #(.DIST_W(8)) bus();

   intrusion_detector #(
      .DIST_W(8), .AVG_LOG2(2), .THRESH_NEAR(100), .THRESH_CLEAR(110),
      .CONFIRM_CNT(3), .ARM_DELAY(8), .TIMEOUT_CYC(100)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   typedef struct {
      int avg;
      int near;
      int state;
   } exp_t;

   exp_t sb[$];
   exp_t pend;
   bit   pend_v = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // Reference model state (0 DISARMED, 1 ARMING, 2 ARMED, 3 ALARM)
   int win[$];
   int m_near = 0, m_state = 0, m_arm_cnt = 0, m_conf = 0, m_last_avg = 0;

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== 32'(exp)) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      win.delete();
      m_near = 0; m_state = 0; m_arm_cnt = 0; m_conf = 0; m_last_avg = 0;
   endtask

   task automatic model_sample(input int s);
      int sum;
      exp_t e;
      if (s == 0) return;
      win.push_back(s);
      if (win.size() > 4) void'(win.pop_front());
      sum = 0;
      foreach (win[i]) sum += win[i];
      m_last_avg = sum / 4;
      if (win.size() == 4) begin
         if (m_last_avg < 100) m_near = 1;
         else if (m_last_avg >= 110) m_near = 0;
         if (m_state == 1) begin
            m_arm_cnt++;
            if (m_arm_cnt == 8) begin m_state = 2; m_conf = 0; end
         end else if (m_state == 2) begin
            if (m_last_avg < 100) begin
               m_conf++;
               if (m_conf == 3) m_state = 3;
            end else begin
               m_conf = 0;
            end
         end
         e.avg = m_last_avg; e.near = m_near; e.state = m_state;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic send(input int s);
      bus.Sample_Valid = 1'b1;
      bus.Sample       = s[7:0];
      model_sample(s);
      @(negedge CLK);
      bus.Sample_Valid = 1'b0;
   endtask

   task automatic set_arm(input bit v);
      idle(3);
      bus.Arm = v;
      idle(2);
      if (!v) begin m_state = 0; m_conf = 0; end
      else if (m_state == 0) begin m_state = 1; m_arm_cnt = 0; end
      chk("arm_state", bus.State, m_state);
      chk("arm_alarm", bus.Alarm, (m_state == 3) ? 1 : 0);
   endtask

   task automatic clear(input bit arm_v);
      idle(3);
      bus.Clear = 1'b1;
      bus.Arm   = arm_v;
      @(negedge CLK);
      bus.Clear = 1'b0;
      if (!arm_v) begin m_state = 0; m_conf = 0; end
      else if (m_state == 3) begin m_state = 1; m_arm_cnt = 0; end
      chk("clear_state", bus.State, m_state);
      chk("clear_alarm", bus.Alarm, (m_state == 3) ? 1 : 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_avg"},   bus.Avg_Distance, 0);
      chk({tag, "_avgv"},  bus.Avg_Valid, 0);
      chk({tag, "_near"},  bus.Near, 0);
      chk({tag, "_alarm"}, bus.Alarm, 0);
      chk({tag, "_state"}, bus.State, 0);
      chk({tag, "_fault"}, bus.Fault, 0);
   endtask

   // Monitor: average on the strobe, Near/State/Alarm one cycle later.
   always @(negedge CLK) begin
      if (pend_v) begin
         chk("near", bus.Near, pend.near);
         chk("state", bus.State, pend.state);
         chk("alarm", bus.Alarm, (pend.state == 3) ? 1 : 0);
         pend_v = 1'b0;
      end
      if (bus.Avg_Valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_avg_valid actual=1 expected=0");
         end else begin
            pend = sb.pop_front();
            chk("avg", bus.Avg_Distance, pend.avg);
            pend_v = 1'b1;
         end
      end
   end

   initial begin
      int hv[5] = '{120, 105, 99, 105, 110};
      int s;
      bus.Sample_Valid = 1'b0;
      bus.Sample       = 8'd0;
      bus.Arm          = 1'b0;
      bus.Clear        = 1'b0;
      model_reset();
      #1 RST = 1'b0;
      #2 chk_all_zero("reset");
      @(negedge CLK);
      RST = 1'b1;
      idle(1);

      // Averaging: 41 then 95
      send(40); send(41); send(42); send(43); send(255);
      idle(3);

      // Hysteresis ladder
      foreach (hv[k]) for (int j = 0; j < 4; j++) send(hv[k]);
      idle(3);
      chk("hyst_final_near", bus.Near, 0);

      // Arm delay, confirm reset by a far average, then alarm
      set_arm(1'b1);
      for (int j = 0; j < 8; j++) send(50);
      idle(3);
      chk("armed_state", bus.State, 2);
      send(50); send(50);
      for (int j = 0; j < 4; j++) send(255);
      for (int j = 0; j < 6; j++) send(50);
      idle(3);
      chk("confirm_alarm", bus.Alarm, 1);

      // Clear with Arm high re-arms; Clear with Arm low disarms
      clear(1'b1);
      for (int j = 0; j < 11; j++) send(50);
      idle(3);
      chk("realarm_state", bus.State, 3);
      clear(1'b0);

      // Zero samples: average untouched, timeout restarted
      send(0); send(0); send(0);
      idle(3);
      chk("zero_avg_hold", bus.Avg_Distance, m_last_avg);
      idle(60);
      send(0);
      idle(60);
      chk("zero_restarts_timeout", bus.Fault, 0);

      // Tamper in ARMED
      set_arm(1'b1);
      for (int j = 0; j < 8; j++) send(50);
      idle(99);
      chk("tamper_fault_early", bus.Fault, 0);
      chk("tamper_state_early", bus.State, 2);
      idle(1);
      chk("tamper_fault", bus.Fault, 1);
      chk("tamper_state", bus.State, 3);
      m_state = 3;
      send(60);
      chk("fault_cleared", bus.Fault, 0);
      chk("fault_state_held", bus.State, 3);

      // Randomized traffic against the model
      clear(1'b1);
      for (int n = 0; n < 300; n++) begin
         s = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(40, 160));
         send(s);
         idle(int'($urandom_range(0, 2)));
         if (m_state == 3 && $urandom_range(0, 3) == 0) clear(1'b1);
         if ($urandom_range(0, 39) == 0) begin
            set_arm(1'b0);
            set_arm(1'b1);
         end
      end

      // Reset mid-operation
      set_arm(1'b0);
      send(70); send(80);
      #2 RST = 1'b0;
      #1 chk_all_zero("midreset");
      sb.delete();
      pend_v = 1'b0;
      model_reset();
      @(negedge CLK);
      RST = 1'b1;
      idle(1);
      send(10); send(20); send(30);
      idle(2);
      chk("no_early_valid", sb.size(), 0);
      send(40);
      idle(3);
      chk("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/intrusion_detector.md
Name: intrusion_detector

Overview:
- Sits directly downstream of the ultrasonic sensor controller. Consumes raw 8-bit distance samples and decides whether an intrusion is present.
- Smooths samples with a 4-tap moving average and applies near/clear hysteresis. Requires consecutive near readings before alarming.
- Runs an arm/disarm state machine. Alarm and state outputs drive the sound generator and codec enable.
- Also detects a silent sensor (tamper/fault).

Parameters:
DIST_W, 8, distance sample width (cm)
AVG_LOG2, 2, log2 of averaging window (window = 4)
THRESH_NEAR, 100, average strictly below this counts as near
THRESH_CLEAR, 110, average at or above this clears Near (must be > THRESH_NEAR)
CONFIRM_CNT, 3, consecutive near averages needed to alarm
ARM_DELAY, 8, averaged samples ignored after arming
TIMEOUT_CYC, 2_000_000, CLK cycles without Sample_Valid before Fault

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-low reset
Sample_Valid  in  1  one-cycle strobe, Sample is valid
Sample  in  DIST_W  raw distance in cm
Arm  in  1  level; 1 = system armed
Clear  in  1  one-cycle pulse; acknowledge alarm
Avg_Distance  out  DIST_W  latest moving average
Avg_Valid  out  1  one-cycle strobe with new Avg_Distance
Near  out  1  hysteresis-filtered near flag
Alarm  out  1  1 while in ALARM
State  out  2  0 DISARMED, 1 ARMING, 2 ARMED, 3 ALARM
Fault  out  1  sensor timeout flag

Behaviour:
- Reset (RST=0, asynchronous): all outputs 0, State=DISARMED, sample buffer/sum/fill count/confirm/arm/timeout counters cleared.
- Sample acceptance:
  - Sample_Valid with Sample==0 (out of range) is ignored for averaging.
  - Sample==0 still restarts the timeout counter.
- Pipeline, for an accepted sample at cycle N:
  - Cycle N+1: push into 4-entry shift buffer; sum updated as sum + new - oldest, width DIST_W+AVG_LOG2; fill count saturates at 4.
  - Avg_Distance = sum >> AVG_LOG2, truncating. It is registered at N+1.
  - Avg_Valid pulses at N+1 only when the fill count is 4, including this sample.
  - Cycle N+2: Near, confirm counter, arm counter and FSM update from the registered average.
- Back-to-back Sample_Valid every cycle must be supported with no loss.
- Near hysteresis, evaluated on each Avg_Valid:
  - avg < THRESH_NEAR -> 1.
  - avg >= THRESH_CLEAR -> 0.
  - Otherwise Near holds.
- Confirm counter, only in ARMED:
  - Each Avg_Valid with avg < THRESH_NEAR increments it, saturating at CONFIRM_CNT.
  - Any other Avg_Valid zeroes it.
  - Reaching CONFIRM_CNT transitions to ALARM in the same N+2 cycle.
- FSM transitions:
  - DISARMED: Arm=1 -> ARMING, arm counter cleared.
  - ARMING: counts Avg_Valid; after ARM_DELAY of them -> ARMED with confirm counter cleared. Near readings are ignored.
  - ARMED: confirm reached -> ALARM. Fault rising (tamper) -> ALARM.
  - ALARM: latched; ignores distance. Clear with Arm=1 -> ARMING (re-arm delay).
  - Any state: Arm=0 -> DISARMED. This includes ALARM, and it takes priority over Clear and over confirm/fault in the same cycle.
- Outputs derived from the FSM: Alarm = (State==ALARM), registered with State.
- Fault (timeout):
  - Counter increments every cycle and clears on any Sample_Valid.
  - At TIMEOUT_CYC, Fault sets and the counter holds.
  - Fault clears in the cycle after the next Sample_Valid.
  - Fault alone never clears ALARM.
- Fill count is not reset by FSM transitions; averaging continues in all states.

Decomposition:
- Shared package holds:
  - the state encoding constants (DISARMED/ARMING/ARMED/ALARM);
  - the default thresholds THRESH_NEAR/THRESH_CLEAR, shared with the sound generator's distance-based pitch logic.
- One natural sub-module, moving_average: shift buffer, running sum, fill count, Avg_Valid. It is parameterised by DIST_W and AVG_LOG2.
- The FSM, hysteresis and timeout live in the top of this block.

Test Plan:
- Reset mid-operation: drive samples, assert RST=0 -> all outputs 0 immediately. After release, the first Avg_Valid appears only after 4 new samples.
- Averaging: samples 40,41,42,43 -> Avg_Valid at N+1 of the 4th, Avg_Distance=41. Next sample 255 -> Avg_Distance=(41+42+43+255)>>2=95.
- Hysteresis:
  - Averages 120,105 -> Near=0.
  - Then 99 -> Near=1.
  - Then 105 -> Near stays 1.
  - Then 110 -> Near=0.
- Arm and confirm:
  - Arm=1, 8 averages of 50 -> State ARMING then ARMED; no alarm during ARMING.
  - Then 50,50,120,50,50 -> no alarm (counter reset).
  - Then a third consecutive 50 -> Alarm=1 at N+2.
- Clear/Arm priority:
  - In ALARM, Clear with Arm=1 -> State=ARMING.
  - In ALARM, Clear with Arm=0 in the same cycle -> State=DISARMED.
  - Sample==0 strobes -> Avg unchanged, timeout restarted.
- Tamper: in ARMED, no Sample_Valid for TIMEOUT_CYC (bench TIMEOUT_CYC=100) -> Fault=1 at cycle 100 and State=ALARM. Next Sample_Valid -> Fault=0, State stays ALARM.
